// File: rtl/mma_controller.sv
// mma_controller: sequencer for an N x N systolic matrix-multiply array.
// Latency: accept -> first operand read 1 cycle. Without stalls, a compute+drain
//   command spends N fetch + 2N compute + N drain cycles, then pulses done_o.
// Backpressure: rd_ready_i / wr_ready_i low stall the FSM indefinitely with
//   address/row/last held stable; commands are accepted only in IDLE.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   cmd_*                    command handshake, phase flags, A/B/C base byte addresses
//   rd_*, feed_last_o        operand read requests feeding the array edge
//   drain_en_o, drain_row_o  array drain control
//   wr_*                     C row write requests
//   busy_o, done_o           status; done_o is a one-cycle completion pulse
//   perf_cycles_o            busy cycles of the last command
// Optional feature macro: MMA_CTRL_PERF_EN (busy-cycle counter; perf_cycles_o is 0 when undefined).

module mma_controller #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYS_ARRAY_SIZE = 2,
  parameter int ADDR_WIDTH     = 64,
  localparam int ROW_W         = (SYS_ARRAY_SIZE > 1) ? $clog2(SYS_ARRAY_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_compute_req_i,
  input  logic                  cmd_drain_en_i,
  input  logic [ADDR_WIDTH-1:0] cmd_a_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_b_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_c_addr_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [ADDR_WIDTH-1:0] rd_a_addr_o,
  output logic [ADDR_WIDTH-1:0] rd_b_addr_o,
  output logic                  feed_last_o,
  output logic                  drain_en_o,
  output logic [ROW_W-1:0]      drain_row_o,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           perf_cycles_o
);

  // One counter serves as slice index k (FETCH), skew timer (COMPUTE) and row r (DRAIN).
  localparam int CNT_W = $clog2(2 * SYS_ARRAY_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(SYS_ARRAY_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_T = CNT_W'(2 * SYS_ARRAY_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(SYS_ARRAY_SIZE * DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] a_base_q, a_base_d;
  logic [ADDR_WIDTH-1:0] b_base_q, b_base_d;
  logic [ADDR_WIDTH-1:0] c_base_q, c_base_d;
  logic                  drain_q, drain_d;
  logic                  cmd_accept;
  logic [ADDR_WIDTH-1:0] offset;

  assign cmd_accept = cmd_valid_i & cmd_ready_o;

  // k*STRIDE or r*STRIDE; address sums wrap modulo 2^ADDR_WIDTH.
  assign offset = ADDR_WIDTH'(cnt_q) * STRIDE;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      drain_q  <= drain_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;
    drain_d  = drain_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          a_base_d = cmd_a_addr_i;
          b_base_d = cmd_b_addr_i;
          c_base_d = cmd_c_addr_i;
          drain_d  = cmd_drain_en_i;
          if (cmd_compute_req_i)   state_d = S_FETCH;
          else if (cmd_drain_en_i) state_d = S_DRAIN;
          else                     state_d = S_DONE;
        end
      end
      S_FETCH: begin
        if (rd_ready_i && cnt_q == LAST_K) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (cnt_q == LAST_T) state_d = drain_q ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        if (wr_ready_i && cnt_q == LAST_K) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Counter restarts at every phase change, otherwise advances on a beat.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_FETCH && rd_ready_i) ||
                 (state_q == S_DRAIN && wr_ready_i) ||
                 (state_q == S_COMPUTE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output logic: everything idles at zero outside its own phase.
  always_comb begin
    cmd_ready_o = 1'b0;
    rd_valid_o  = 1'b0;
    rd_a_addr_o = '0;
    rd_b_addr_o = '0;
    feed_last_o = 1'b0;
    drain_en_o  = 1'b0;
    drain_row_o = '0;
    wr_valid_o  = 1'b0;
    wr_addr_o   = '0;
    done_o      = 1'b0;
    busy_o      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = rst_n;
      end
      S_FETCH: begin
        rd_valid_o  = 1'b1;
        rd_a_addr_o = a_base_q + offset;
        rd_b_addr_o = b_base_q + offset;
        feed_last_o = (cnt_q == LAST_K);
      end
      S_DRAIN: begin
        drain_en_o  = 1'b1;
        wr_valid_o  = 1'b1;
        drain_row_o = cnt_q[ROW_W-1:0];
        wr_addr_o   = c_base_q + offset;
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef MMA_CTRL_PERF_EN
  logic [31:0] perf_cnt_q;
  logic [31:0] perf_out_q;
  logic [31:0] perf_inc;

  // Saturating increment; the DONE cycle itself is included in the reported count.
  assign perf_inc = (perf_cnt_q == 32'hFFFF_FFFF) ? perf_cnt_q : perf_cnt_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt_q <= '0;
      perf_out_q <= '0;
    end else begin
      if (cmd_accept)  perf_cnt_q <= '0;
      else if (busy_o) perf_cnt_q <= perf_inc;
      if (state_q == S_DONE) perf_out_q <= perf_inc;
    end
  end

  assign perf_cycles_o = perf_out_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_mma_controller.sv
// Self-checking bench for mma_controller (N = 2, STRIDE = 2 bytes).
// Stimulus pushes expected read beats, write beats and done cycles into queues;
// a negedge monitor compares them against whatever the DUT presents.

module tb_mma_controller;

  localparam int N = 2;
  localparam logic [63:0] STRIDE = 64'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_compute_req_i, cmd_drain_en_i;
  logic [63:0] cmd_a_addr_i, cmd_b_addr_i, cmd_c_addr_i;
  logic        rd_valid_o, rd_ready_i, feed_last_o;
  logic [63:0] rd_a_addr_o, rd_b_addr_o;
  logic        drain_en_o;
  logic [0:0]  drain_row_o;
  logic        wr_valid_o, wr_ready_i;
  logic [63:0] wr_addr_o;
  logic        busy_o, done_o;
  logic [31:0] perf_cycles_o;

  always #5 clk = ~clk;

  mma_controller #(.DATA_WIDTH(8), .SYS_ARRAY_SIZE(N), .ADDR_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_compute_req_i(cmd_compute_req_i), .cmd_drain_en_i(cmd_drain_en_i),
    .cmd_a_addr_i(cmd_a_addr_i), .cmd_b_addr_i(cmd_b_addr_i), .cmd_c_addr_i(cmd_c_addr_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_a_addr_o(rd_a_addr_o), .rd_b_addr_o(rd_b_addr_o), .feed_last_o(feed_last_o),
    .drain_en_o(drain_en_o), .drain_row_o(drain_row_o),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o),
    .busy_o(busy_o), .done_o(done_o), .perf_cycles_o(perf_cycles_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        last;
  } rd_exp_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [0:0]  row;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the head of each queue must match while valid is up (so stalled
  // beats are checked for stability too); it is retired on the handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid_o) begin
        if (rd_q.size() == 0) begin
          check("rd_unexpected_valid", {63'd0, rd_valid_o}, 64'd0);
        end else begin
          check("rd_a_addr", rd_a_addr_o, rd_q[0].a);
          check("rd_b_addr", rd_b_addr_o, rd_q[0].b);
          check("feed_last", {63'd0, feed_last_o}, {63'd0, rd_q[0].last});
          if (rd_ready_i) void'(rd_q.pop_front());
        end
      end
      if (wr_valid_o) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected_valid", {63'd0, wr_valid_o}, 64'd0);
        end else begin
          check("wr_addr", wr_addr_o, wr_q[0].addr);
          check("drain_row", {63'd0, drain_row_o}, {63'd0, wr_q[0].row});
          check("drain_en", {63'd0, drain_en_o}, 64'd1);
          if (wr_ready_i) void'(wr_q.pop_front());
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", {63'd0, done_o}, 64'd0);
        end else begin
          check("done_cycle", 64'(cyc), 64'(done_q[0]));
          void'(done_q.pop_front());
        end
      end
    end
  end

  // Issue one command, push its expected beats, optionally stall read k=1 for
  // three cycles, then wait (bounded) for done_o.
  task automatic send_cmd(input bit comp, input bit drn, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] c,
                          input int lat, input bit stall);
    int  acc;
    bit  got;
    rd_exp_t re;
    wr_exp_t we;
    @(posedge clk); #1;
    cmd_compute_req_i = comp;
    cmd_drain_en_i    = drn;
    cmd_a_addr_i      = a;
    cmd_b_addr_i      = b;
    cmd_c_addr_i      = c;
    cmd_valid_i       = 1'b1;
    got = 0;
    acc = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        got = 1;
        acc = cyc;
      end
    end
    if (!got) begin
      check("accept_timeout", {63'd0, cmd_ready_o}, 64'd1);
      cmd_valid_i = 1'b0;
      return;
    end
    if (comp) begin
      for (int k = 0; k < N; k++) begin
        re.a = a + 64'(k) * STRIDE;
        re.b = b + 64'(k) * STRIDE;
        re.last = (k == N - 1);
        rd_q.push_back(re);
      end
    end
    if (drn) begin
      for (int r = 0; r < N; r++) begin
        we.addr = c + 64'(r) * STRIDE;
        we.row  = 1'(r);
        wr_q.push_back(we);
      end
    end
    done_q.push_back(acc + lat);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    // Garbage on the command bus after accept must be ignored.
    cmd_a_addr_i = 64'hDEAD_BEEF_0000_0000;
    cmd_b_addr_i = 64'hDEAD_BEEF_1111_1111;
    cmd_c_addr_i = 64'hDEAD_BEEF_2222_2222;
    cmd_compute_req_i = ~comp;
    cmd_drain_en_i    = ~drn;
    if (stall) begin
      @(posedge clk); #1;
      rd_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rd_ready_i = 1'b1;
    end
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done_o) got = 1;
    end
    if (!got) check("done_timeout", {63'd0, done_o}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int prev;
    int n_acc;
    rst_n = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_compute_req_i = 1'b0;
    cmd_drain_en_i = 1'b0;
    cmd_a_addr_i = '0;
    cmd_b_addr_i = '0;
    cmd_c_addr_i = '0;
    rd_ready_i = 1'b1;
    wr_ready_i = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {63'd0, cmd_ready_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_rd_valid", {63'd0, rd_valid_o}, 64'd0);
    check("rst_wr_valid", {63'd0, wr_valid_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_perf", {32'd0, perf_cycles_o}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", {63'd0, cmd_ready_o}, 64'd1);

    // Full compute+drain command, no stalls: done 9 cycles after accept
    send_cmd(1, 1, 64'h100, 64'h200, 64'h300, 9, 0);
    @(negedge clk);
`ifdef MMA_CTRL_PERF_EN
    check("perf_cycles", {32'd0, perf_cycles_o}, 64'd9);
`else
    check("perf_cycles", {32'd0, perf_cycles_o}, 64'd0);
`endif

    // Read k=1 stalled 3 cycles: done delayed to 12
    send_cmd(1, 1, 64'h100, 64'h200, 64'h300, 12, 1);

    // Compute only (no writes), then drain only
    send_cmd(1, 0, 64'h400, 64'h500, 64'h600, 7, 0);
    send_cmd(0, 1, 64'h0, 64'h0, 64'h300, 3, 0);

    // Neither flag: done the cycle after accept
    send_cmd(0, 0, 64'h0, 64'h0, 64'h0, 1, 0);

    // Back-to-back accepts with cmd_valid_i held high
    @(posedge clk); #1;
    cmd_compute_req_i = 1'b0;
    cmd_drain_en_i = 1'b0;
    cmd_valid_i = 1'b1;
    prev = -1;
    n_acc = 0;
    repeat (7) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        done_q.push_back(cyc + 1);
        if (prev >= 0) check("b2b_gap", 64'(cyc - prev), 64'd2);
        prev = cyc;
        n_acc++;
      end
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    check("b2b_accepts", 64'(n_acc), 64'd4);
    repeat (3) @(negedge clk);

    // Reset for one cycle while in DRAIN (write stalled): back to IDLE, no done
    wr_ready_i = 1'b0;
    @(posedge clk); #1;
    cmd_compute_req_i = 1'b0;
    cmd_drain_en_i = 1'b1;
    cmd_c_addr_i = 64'h700;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    check("rstmid_accept", {63'd0, cmd_ready_o}, 64'd1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_in_drain", {63'd0, wr_valid_o}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_ready_i = 1'b1;
    @(negedge clk);
    check("rstmid_busy", {63'd0, busy_o}, 64'd0);
    check("rstmid_wr_valid", {63'd0, wr_valid_o}, 64'd0);
    check("rstmid_drain_en", {63'd0, drain_en_o}, 64'd0);
    check("rstmid_wr_addr", wr_addr_o, 64'd0);
    check("rstmid_done", {63'd0, done_o}, 64'd0);
    check("rstmid_cmd_ready", {63'd0, cmd_ready_o}, 64'd1);
    repeat (4) @(negedge clk);
    send_cmd(1, 1, 64'h1000, 64'h2000, 64'h3000, 9, 0);

    // C base at the top of the address space: second row wraps to 0x1
    send_cmd(0, 1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 3, 0);

    repeat (5) @(negedge clk);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check("done_q_drained", 64'(done_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mma_controller.md
# mma_controller

Sequencer for the SYS_ARRAY_SIZE×SYS_ARRAY_SIZE systolic matrix-multiply array. It accepts one control command at a time: compute request, drain enable and A/B/C base addresses. It then issues the A/B operand reads that feed the array edge, waits out the systolic skew, and drains the C accumulators back to memory one row per write. It sits between the command source and the array/memory interfaces.

## Interface
- DATA_WIDTH, 8, element width in bits
- SYS_ARRAY_SIZE, 2, array dimension N
- ADDR_WIDTH, 64, byte address width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_compute_req_i  in  1  run fetch+compute phase
- cmd_drain_en_i  in  1  run drain phase
- cmd_a_addr_i / cmd_b_addr_i / cmd_c_addr_i  in  ADDR_WIDTH each  base byte addresses
- rd_valid_o  out  1  operand read request
- rd_ready_i  in  1  read accepted
- rd_a_addr_o / rd_b_addr_o  out  ADDR_WIDTH  A column / B row address
- feed_last_o  out  1  marks last operand slice (drives PE `last`)
- drain_en_o  out  1  array drain enable
- drain_row_o  out  $clog2(N) (min 1)  row being drained
- wr_valid_o  out  1  C row write request
- wr_ready_i  in  1  write accepted
- wr_addr_o  out  ADDR_WIDTH  C row address
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle completion pulse
- perf_cycles_o  out  32  busy cycles of last command (see Configuration)

## Operation
- States: IDLE, FETCH, COMPUTE, DRAIN, DONE.
- IDLE: cmd_ready_o = 1 while rst_n = 1. On accept, the bases and flags are latched; inputs are ignored thereafter.
- IDLE transitions: compute_req → FETCH; else drain_en → DRAIN; else → DONE.
- FETCH: slice counter k = 0..N-1.
  - rd_valid_o = 1.
  - rd_a_addr_o = a_base + k·STRIDE; rd_b_addr_o = b_base + k·STRIDE.
  - STRIDE = N·DATA_WIDTH/8 bytes.
  - feed_last_o = 1 when k = N-1.
  - k advances only on rd_valid_o & rd_ready_i. Address and last are held stable while stalled.
  - Accept of k = N-1 → COMPUTE.
- COMPUTE: counts T_D = 2N cycles (skew fill and flush). Then → DRAIN if drain_en, else → DONE. Without drain, the accumulators keep their values for the next command.
- DRAIN: row counter r = 0..N-1.
  - drain_en_o = 1, wr_valid_o = 1, drain_row_o = r.
  - wr_addr_o = c_base + r·STRIDE.
  - r advances on wr_valid_o & wr_ready_i. Accept of r = N-1 → DONE.
- DONE: done_o = 1 for exactly one cycle → IDLE.
- Address arithmetic: modulo 2^ADDR_WIDTH; carry out is discarded.

## Timing
- Reset values: all outputs 0. Counters 0, state IDLE. cmd_ready_o = 0 while rst_n = 0.
- Reset asserted mid-command: the next edge returns to IDLE. Outstanding read/write requests are dropped, and no done_o is produced.
- Accept edge to first rd_valid_o: 1 cycle.
- Reads and writes drop their valid on the same edge that accepts the last beat.
- Minimum latency with compute+drain and no stalls: accept at cycle 0, FETCH 1..N, COMPUTE N+1..3N, DRAIN 3N+1..4N, done_o at 4N+1.
- cmd_valid_i during busy: not accepted. The first accept is possible in the cycle after done_o.
- rd_ready_i or wr_ready_i held low: the FSM stalls indefinitely. No timeout.

## Configuration
- MMA_CTRL_PERF_EN defined:
  - A 32-bit counter increments every cycle busy_o = 1, saturating at 2^32-1.
  - It clears on command accept.
  - perf_cycles_o is updated with the final count in the DONE cycle and held until the next DONE.
- Not defined: perf_cycles_o is tied to 0 and no counter is synthesized.

## Test plan
Default parameters (N = 2, STRIDE = 2).
- Full command, a = 0x100, b = 0x200, c = 0x300, compute and drain set, ready inputs always 1:
  - rd addresses are (0x100, 0x200) then (0x102, 0x202); feed_last_o only on the second.
  - wr addresses are 0x300 then 0x302, with drain_row_o 0 then 1.
  - done_o at cycle 9.
- rd_ready_i low for 3 cycles on k = 1: address 0x102/0x202 and feed_last_o are held stable; done_o is delayed to cycle 12.
- compute = 1, drain = 0: no wr_valid_o and done_o at cycle 7. Then a drain-only command produces 2 writes and done_o 3 cycles after accept.
- Both flags 0: done_o the cycle after accept. cmd_valid_i held high gives back-to-back accepts every 2 cycles.
- rst_n low for 1 cycle during DRAIN: the next cycle shows IDLE, all outputs 0 and no done_o. A new command then completes normally.
- Base c = 0xFFFF_FFFF_FFFF_FFFF: the second write address wraps to 0x1.
- With MMA_CTRL_PERF_EN defined: perf_cycles_o = 9 after the full no-stall command.
